mmio_tx_responder: RTL
======================

// Module: mmio_tx_responder
// PURPOSE
//  Memory-mapped I/O responder on the processor data port (address/data/MemRead/MemWrite).
//  Serves processor loads/stores to a 4-byte window: switch input, LED register, TX data, status.
//  Bytes stored to TX data go into a small FIFO, then out as 8N1 serial frames on tx_out.
//  The top level muxes rdata over memory q when rhit=1.
// PARAMETERS
//  BASE_ADDR   8'hFC  first address of the 4-byte window (low 2 bits must be 0)
//  FIFO_DEPTH  4      TX FIFO entries (power of 2, 2..8)
//  BAUD_DIV    16     clock cycles per serial bit (>=2)
// PORTS
//  clock     in   1  system clock, all state on rising edge
//  reset     in   1  asynchronous, active-high
//  mem_read  in   1  processor data-port read strobe
//  mem_write in   1  processor data-port write strobe
//  address   in   8  processor data address
//  wdata     in   8  processor store data
//  rdata     out  8  registered load data (valid the cycle after the request)
//  rhit      out  1  registered: rdata is from this block
//  sw_in     in   8  asynchronous switch inputs
//  led_out   out  8  LED register
//  tx_out    out  1  serial line, idle high
//  tx_busy   out  1  a frame is in progress
// BEHAVIOUR
//  Reset values: rdata=0, rhit=0, led_out=0, tx_out=1, tx_busy=0, FIFO empty, overflow=0, FSM=IDLE.
//  Decode: hit = address[7:2]==BASE_ADDR[7:2]. Off = address[1:0].
//  Off 0 SW: read gives sw_in after a 2-flop synchronizer. Writes are ignored.
//  Off 1 LED: read/write. Write updates led_out at the edge of the write.
//  Off 2 TXDATA: write pushes wdata. Read returns 8'h00.
//  Off 3 STATUS: read gives {ovf, count[2:0], 1'b0, tx_busy, full, empty}.
//   A write of any value clears ovf.
//  Read: at edge with mem_read & hit: rdata<=selected value, rhit<=1. Otherwise rdata<=0, rhit<=0.
//  mem_read & mem_write in the same cycle: the write takes effect and the read returns the pre-write value.
//  FIFO push: write to TXDATA when not full. If full, the byte is dropped and ovf<=1 (sticky).
//  Simultaneous push+pop while full: push is accepted and count is unchanged.
//  Pop is driven only by the FSM and requires empty=0.
//  FSM IDLE/START/DATA/STOP, baud counter 0..BAUD_DIV-1, bit index 0..7:
//   IDLE: tx_out=1. If !empty, pop into shift reg, go START, baud=0.
//   START: tx_out=0 for BAUD_DIV cycles, then go DATA, bit=0.
//   DATA: tx_out=shift[0] (LSB first). Shift every BAUD_DIV cycles. After bit 7 go STOP.
//   STOP: tx_out=1 for BAUD_DIV cycles. Then, if !empty, pop and go START directly (back-to-back). Else go IDLE.
//  Frame = 10*BAUD_DIV cycles. tx_busy=1 in START/DATA/STOP.
//  tx_out and tx_busy are registered (glitch-free).
//  count saturates at FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
//  Async reset mid-frame: tx_out goes to 1 immediately and queued bytes are discarded.
//  Out-of-window accesses have no effect (rhit=0).
// STRUCTURE
//  Package mmio_pkg: offset constants SW/LED/TXDATA/STATUS, FSM state encoding,
//   STATUS bit positions.
//  Sub-module sync_fifo_8bit (parameter DEPTH): push/pop/full/empty/count.
//  Top: decode, read mux/register, synchronizer, baud counter, FSM.
// TESTING (BAUD_DIV=4, FIFO_DEPTH=4, BASE_ADDR=8'hFC)
//  Reset, then read 0xFF -> next cycle rhit=1, rdata=8'h01 (empty); tx_out=1, led_out=0.
//  Write 0xFD=8'hA5, then read 0xFD -> led_out=8'hA5, rdata=8'hA5.
//   Read 0x10 -> rhit=0.
//  Write 0xFE=8'h53 -> tx_busy the next cycle, then tx_out sequence over 40 cycles:
//   0, 1,1,0,0,1,0,1,0, 1 (4 cycles each).
//  Write 5 bytes back-to-back while idle -> 1st is popped, 4 are held, none dropped.
//   Then 2 more -> ovf=1, STATUS[7]=1. Write 0xFF -> ovf=0.
//   Frames are contiguous with no idle gap between stop and the next start.
//  Assert reset at cycle 13 of a frame -> tx_out=1 and tx_busy=0 at once, FIFO empty after release.
//  Set sw_in=8'h3C, then read 0xFC 3 cycles later -> rdata=8'h3C.

Source files
------------

// File: rtl/mmio_tx_responder_pkg.sv
// Shared constants for the MMIO responder: window offsets, transmitter states
// and the STATUS register layout.
package mmio_pkg;

    localparam logic [1:0] OFF_SW     = 2'd0;
    localparam logic [1:0] OFF_LED    = 2'd1;
    localparam logic [1:0] OFF_TXDATA = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    localparam int ST_EMPTY  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_BUSY   = 2;
    localparam int ST_CNT_LO = 4;
    localparam int ST_OVF    = 7;

    function automatic logic [7:0] status_word(input logic       ovf,
                                               input logic [2:0] cnt,
                                               input logic       busy,
                                               input logic       full,
                                               input logic       empty);
        logic [7:0] s;
        s                        = 8'h00;
        s[ST_OVF]                = ovf;
        s[ST_CNT_LO+2:ST_CNT_LO] = cnt;
        s[ST_BUSY]               = busy;
        s[ST_FULL]               = full;
        s[ST_EMPTY]              = empty;
        return s;
    endfunction

endpackage

// File: rtl/mmio_tx_responder_fifo.sv
// Byte FIFO feeding the serial transmitter; head entry is visible on rdata_o
// without a pop so the FSM can load it in the same cycle it pops.
module sync_fifo_8bit #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees the slot in the same edge, so a push while full is still accepted then.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mmio_tx_responder.sv
// MMIO responder: switch/LED/TX-data/status window on the processor data port,
// with a FIFO-fed 8N1 serial transmitter.
module mmio_tx_responder
    import mmio_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'hFC,
    parameter int         FIFO_DEPTH = 4,
    parameter int         BAUD_DIV   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic [7:0] address,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       rhit,
    input  logic [7:0] sw_in,
    output logic [7:0] led_out,
    output logic       tx_out,
    output logic       tx_busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(BAUD_DIV);

    logic          hit;
    logic [1:0]    off;
    logic          wr_led, wr_tx, wr_status, drop;
    logic [7:0]    rd_val;
    logic [7:0]    sw_s1_q, sw_s2_q, led_q, rdata_q;
    logic          rhit_q, ovf_q;

    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;

    tx_state_e     state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q, busy_q, baud_last;

    assign hit       = (address[7:2] == BASE_ADDR[7:2]);
    assign off       = address[1:0];
    assign wr_led    = mem_write & hit & (off == OFF_LED);
    assign wr_tx     = mem_write & hit & (off == OFF_TXDATA);
    assign wr_status = mem_write & hit & (off == OFF_STATUS);
    assign drop      = wr_tx & fifo_full & ~fifo_pop;

    assign rdata   = rdata_q;
    assign rhit    = rhit_q;
    assign led_out = led_q;
    assign tx_out  = tx_q;
    assign tx_busy = busy_q;

    sync_fifo_8bit #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (wr_tx),
        .pop_i   (fifo_pop),
        .wdata_i (wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Reads see current register state, so a same-cycle write returns the old value.
    always_comb begin
        rd_val = 8'h00;
        case (off)
            OFF_SW:     rd_val = sw_s2_q;
            OFF_LED:    rd_val = led_q;
            OFF_TXDATA: rd_val = 8'h00;
            OFF_STATUS: rd_val = status_word(ovf_q, 3'(fifo_count), busy_q,
                                             fifo_full, fifo_empty);
            default:    rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_s1_q <= 8'h00;
            sw_s2_q <= 8'h00;
            led_q   <= 8'h00;
            ovf_q   <= 1'b0;
            rdata_q <= 8'h00;
            rhit_q  <= 1'b0;
        end else begin
            sw_s1_q <= sw_in;
            sw_s2_q <= sw_s1_q;
            if (wr_led) led_q <= wdata;
            if (wr_status)  ovf_q <= 1'b0;
            else if (drop)  ovf_q <= 1'b1;
            rdata_q <= (mem_read & hit) ? rd_val : 8'h00;
            rhit_q  <= mem_read & hit;
        end
    end

    assign baud_last = (baud_q == BW'(BAUD_DIV - 1));
    assign fifo_pop  = ~fifo_empty &
                       ((state_q == TX_IDLE) || ((state_q == TX_STOP) && baud_last));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= TX_START;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                TX_START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= 3'd0;
                        state_q <= TX_DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                TX_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= TX_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                TX_STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        // Next byte starts without an idle gap when one is queued.
                        if (!fifo_empty) begin
                            state_q <= TX_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= TX_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (fifo_pop)
            shift_q <= fifo_rdata;
        else if ((state_q == TX_DATA) && baud_last)
            shift_q <= {1'b0, shift_q[7:1]};
    end

endmodule
